// File: rtl/raster_sched_pkg.sv
// Shared definitions for the triangle raster scheduler: field widths,
// packet length, FSM state encoding and the triangle record layout.
package raster_sched_pkg;

    localparam int X_W       = 7;
    localparam int Y_W       = 6;
    localparam int COL_W     = 6;
    localparam int TRI_BYTES = 7;
    localparam int CNT_W     = 3;
    localparam int BYTE_W    = 8;

    // Byte positions inside a triangle packet
    localparam logic [CNT_W-1:0] IDX_V0_X = 3'd0;
    localparam logic [CNT_W-1:0] IDX_V0_Y = 3'd1;
    localparam logic [CNT_W-1:0] IDX_V1_X = 3'd2;
    localparam logic [CNT_W-1:0] IDX_V1_Y = 3'd3;
    localparam logic [CNT_W-1:0] IDX_V2_X = 3'd4;
    localparam logic [CNT_W-1:0] IDX_V2_Y = 3'd5;
    localparam logic [CNT_W-1:0] IDX_COL  = 3'd6;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   v0_x;
        logic [Y_W-1:0]   v0_y;
        logic [X_W-1:0]   v1_x;
        logic [Y_W-1:0]   v1_y;
        logic [X_W-1:0]   v2_x;
        logic [Y_W-1:0]   v2_y;
        logic [COL_W-1:0] colour;
    } tri_t;

    // True for the byte positions that carry an X coordinate
    function automatic logic is_x_byte(input logic [CNT_W-1:0] idx);
        return (idx == IDX_V0_X) || (idx == IDX_V1_X) || (idx == IDX_V2_X);
    endfunction

endpackage

// File: rtl/raster_sched_tri_regs.sv
// Shadow/active triangle register pair. Bytes land in the shadow set one
// field at a time; a swap copies the whole shadow set to the active set,
// which is what the raster core sees.
module tri_regs
    import raster_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              swap,
    output logic [X_W-1:0]    v0_x,
    output logic [X_W-1:0]    v1_x,
    output logic [X_W-1:0]    v2_x,
    output logic [Y_W-1:0]    v0_y,
    output logic [Y_W-1:0]    v1_y,
    output logic [Y_W-1:0]    v2_y,
    output logic [COL_W-1:0]  colour
);

    tri_t shadow;
    tri_t active;

    // X fields take the low 7 bits, Y and colour the low 6; the rest is dropped
    logic [X_W-1:0] x_field;
    logic [Y_W-1:0] y_field;
    logic           unused_top_bit;

    assign x_field        = wr_data[X_W-1:0];
    assign y_field        = wr_data[Y_W-1:0];
    assign unused_top_bit = wr_data[BYTE_W-1];

    // Steer an accepted byte into its shadow field
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                IDX_V0_X: shadow.v0_x   <= x_field;
                IDX_V0_Y: shadow.v0_y   <= y_field;
                IDX_V1_X: shadow.v1_x   <= x_field;
                IDX_V1_Y: shadow.v1_y   <= y_field;
                IDX_V2_X: shadow.v2_x   <= x_field;
                IDX_V2_Y: shadow.v2_y   <= y_field;
                IDX_COL:  shadow.colour <= y_field;
                default:  ;
            endcase
        end
    end

    // Publish the complete shadow triangle to the raster core on swap
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
        end else if (swap) begin
            active <= shadow;
        end
    end

    assign v0_x   = active.v0_x;
    assign v0_y   = active.v0_y;
    assign v1_x   = active.v1_x;
    assign v1_y   = active.v1_y;
    assign v2_x   = active.v2_x;
    assign v2_y   = active.v2_y;
    assign colour = active.colour;

endmodule

// File: rtl/raster_sched.sv
// Triangle raster scheduler. Collects 7-byte triangle packets into a shadow
// register while the current triangle is displayed, then swaps the new one
// in at the start of vertical blanking so the raster core never sees a
// half-updated triangle.
module raster_sched
    import raster_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             frame_start,
    input  logic             clear,
    input  logic             rasterize,
    output logic [X_W-1:0]   v0_x,
    output logic [X_W-1:0]   v1_x,
    output logic [X_W-1:0]   v2_x,
    output logic [Y_W-1:0]   v0_y,
    output logic [Y_W-1:0]   v1_y,
    output logic [Y_W-1:0]   v2_y,
    output logic [COL_W-1:0] colour,
    output logic             pixel_on,
    output logic             pending
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TRI_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic             active_valid;

    // A byte offered alongside clear is dropped; clear also blocks the swap.
    // in_ready is a register, so neither term depends combinationally on in_valid
    // reaching in_ready.
    logic xfer;
    logic swap;

    assign xfer = in_valid && in_ready && !clear;
    assign swap = frame_start && (state == ST_FULL) && !clear;

    // Packet FSM: count bytes in LOAD, wait for frame_start in FULL
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LOAD;
            byte_cnt     <= '0;
            active_valid <= 1'b0;
            in_ready     <= 1'b1;
            pending      <= 1'b0;
        end else if (clear) begin
            state        <= ST_LOAD;
            byte_cnt     <= '0;
            active_valid <= 1'b0;
            in_ready     <= 1'b1;
            pending      <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // frame_start is ignored here, even on the final byte
                    if (xfer) begin
                        if (byte_cnt == LAST_IDX) begin
                            byte_cnt <= '0;
                            state    <= ST_FULL;
                            in_ready <= 1'b0;
                            pending  <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (swap) begin
                        state        <= ST_LOAD;
                        active_valid <= 1'b1;
                        in_ready     <= 1'b1;
                        pending      <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    byte_cnt <= '0;
                    in_ready <= 1'b1;
                    pending  <= 1'b0;
                end
            endcase
        end
    end

    tri_regs u_tri_regs (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (xfer),
        .wr_idx  (byte_cnt),
        .wr_data (in_data),
        .swap    (swap),
        .v0_x    (v0_x),
        .v1_x    (v1_x),
        .v2_x    (v2_x),
        .v0_y    (v0_y),
        .v1_y    (v1_y),
        .v2_y    (v2_y),
        .colour  (colour)
    );

    assign pixel_on = rasterize && active_valid;

endmodule

// File: tb/tb_raster_sched.sv
// Testbench for raster_sched: a table of directed vectors, hand-written
// multi-cycle corner cases and a randomized run against a packet-level model.
module tb_raster_sched;
    import raster_sched_pkg::*;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             frame_start;
    logic             clear;
    logic             rasterize;
    logic [X_W-1:0]   v0_x, v1_x, v2_x;
    logic [Y_W-1:0]   v0_y, v1_y, v2_y;
    logic [COL_W-1:0] colour;
    logic             pixel_on;
    logic             pending;

    int n_cmp;
    int n_bad;

    raster_sched dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .clear       (clear),
        .rasterize   (rasterize),
        .v0_x        (v0_x),
        .v1_x        (v1_x),
        .v2_x        (v2_x),
        .v0_y        (v0_y),
        .v1_y        (v1_y),
        .v2_y        (v2_y),
        .colour      (colour),
        .pixel_on    (pixel_on),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet-level reference: fields received so far, the displayed triangle,
    // and how many bytes of the current packet have arrived (7 = complete).
    int m_sh[7];
    int m_act[7];
    int m_n;
    bit m_av;

    task automatic model_step(input bit r, input bit iv, input int d, input bit fs, input bit cl);
        if (r) begin
            m_n = 0;
            m_av = 0;
            for (int k = 0; k < 7; k++) begin
                m_sh[k] = 0;
                m_act[k] = 0;
            end
        end else if (cl) begin
            m_n = 0;
            m_av = 0;
        end else if (m_n == 7) begin
            if (fs) begin
                m_act = m_sh;
                m_av = 1;
                m_n = 0;
            end
        end else if (iv) begin
            // positions 0,2,4 are X coordinates (7 bits), the rest 6 bits
            m_sh[m_n] = (m_n % 2 == 0 && m_n < 6) ? (d % 128) : (d % 64);
            m_n = m_n + 1;
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".v0_x"}, 32'(v0_x), 32'(m_act[0]));
        cmp({tag, ".v0_y"}, 32'(v0_y), 32'(m_act[1]));
        cmp({tag, ".v1_x"}, 32'(v1_x), 32'(m_act[2]));
        cmp({tag, ".v1_y"}, 32'(v1_y), 32'(m_act[3]));
        cmp({tag, ".v2_x"}, 32'(v2_x), 32'(m_act[4]));
        cmp({tag, ".v2_y"}, 32'(v2_y), 32'(m_act[5]));
        cmp({tag, ".colour"}, 32'(colour), 32'(m_act[6]));
        cmp({tag, ".in_ready"}, 32'(in_ready), 32'(m_n < 7));
        cmp({tag, ".pending"}, 32'(pending), 32'(m_n == 7));
        cmp({tag, ".pixel_on"}, 32'(pixel_on), 32'(rasterize && m_av));
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic cyc(input bit r, input bit iv, input logic [7:0] d,
                       input bit fs, input bit cl, input bit ras);
        rst = r;
        in_valid = iv;
        in_data = d;
        frame_start = fs;
        clear = cl;
        rasterize = ras;
        model_step(r, iv, int'(d), fs, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int cnt, input logic [7:0] d);
        for (int k = 0; k < cnt; k++) begin
            cyc(0, 1, d, 0, 0, 1);
            check_model("send");
        end
    endtask

    typedef struct {
        bit         r, iv;
        logic [7:0] d;
        bit         fs, cl, ras;
        bit         e_rdy, e_pend, e_pix;
        int         e_v0x, e_col;
    } vec_t;

    vec_t tbl[11];
    logic [7:0] pkt[7];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1; in_valid = 0; in_data = 0; frame_start = 0; clear = 0; rasterize = 0;
        m_n = 0; m_av = 0;
        for (int k = 0; k < 7; k++) begin
            m_sh[k] = 0;
            m_act[k] = 0;
        end
        #2;

        pkt[0] = 8'h0A; pkt[1] = 8'h05; pkt[2] = 8'h50; pkt[3] = 8'h05;
        pkt[4] = 8'h2D; pkt[5] = 8'h30; pkt[6] = 8'h3F;

        //            r  iv d      fs cl ras rdy pend pix v0x col
        tbl[0]  = '{1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 0};
        for (int k = 0; k < 7; k++)
            tbl[1+k] = '{0, 1, pkt[k], 0, 0, 1, (k != 6), (k == 6), 0, 0, 0};
        tbl[8]  = '{0, 1, 8'h7F, 0, 0, 1, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 8'h00, 1, 0, 1, 1, 0, 1, 10, 63};
        tbl[10] = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 10, 63};

        // Directed table: reset, reference packet, back-pressure, swap, ignored frame_start
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].fs, tbl[i].cl, tbl[i].ras);
            cmp($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            cmp($sformatf("tbl%0d.pending", i), 32'(pending), 32'(tbl[i].e_pend));
            cmp($sformatf("tbl%0d.pixel_on", i), 32'(pixel_on), 32'(tbl[i].e_pix));
            cmp($sformatf("tbl%0d.v0_x", i), 32'(v0_x), 32'(tbl[i].e_v0x));
            cmp($sformatf("tbl%0d.colour", i), 32'(colour), 32'(tbl[i].e_col));
            check_model($sformatf("tbl%0d", i));
        end
        cmp("ref.v0_y", 32'(v0_y), 32'd5);
        cmp("ref.v1_x", 32'(v1_x), 32'd80);
        cmp("ref.v1_y", 32'(v1_y), 32'd5);
        cmp("ref.v2_x", 32'(v2_x), 32'd45);
        cmp("ref.v2_y", 32'(v2_y), 32'd48);

        // Final byte coincides with frame_start: accepted, no swap yet
        send_bytes(6, 8'h11);
        cyc(0, 1, 8'h22, 1, 0, 1);
        check_model("lastfs");
        cmp("lastfs.pending", 32'(pending), 32'd1);
        cmp("lastfs.colour_kept", 32'(colour), 32'd63);
        cmp("lastfs.v0_x_kept", 32'(v0_x), 32'd10);
        cyc(0, 0, 8'h00, 0, 0, 1);
        check_model("lastfs.idle");
        cyc(0, 0, 8'h00, 1, 0, 1);
        check_model("lastfs.swap");
        cmp("lastfs.swap_v0_x", 32'(v0_x), 32'h11);
        cmp("lastfs.swap_colour", 32'(colour), 32'h22);

        // Partial packet then clear (with a byte offered that cycle), then a fresh packet
        send_bytes(3, 8'h55);
        cyc(0, 1, 8'h66, 0, 1, 1);
        check_model("clr");
        cmp("clr.pixel_on", 32'(pixel_on), 32'd0);
        cmp("clr.in_ready", 32'(in_ready), 32'd1);
        cmp("clr.v0_x_kept", 32'(v0_x), 32'h11);
        for (int k = 0; k < 7; k++) begin
            cyc(0, 1, pkt[k], 0, 0, 1);
            check_model("clr.reload");
        end
        cyc(0, 0, 8'h00, 1, 0, 1);
        check_model("clr.swap");
        cmp("clr.swap_v0_x", 32'(v0_x), 32'd10);
        cmp("clr.swap_v2_y", 32'(v2_y), 32'd48);
        cmp("clr.swap_pixel_on", 32'(pixel_on), 32'd1);

        // clear and frame_start together while a packet is waiting
        send_bytes(7, 8'h01);
        cyc(0, 0, 8'h00, 1, 1, 1);
        check_model("clrfs");
        cmp("clrfs.pending", 32'(pending), 32'd0);
        cmp("clrfs.in_ready", 32'(in_ready), 32'd1);
        cmp("clrfs.no_swap_v0_x", 32'(v0_x), 32'd10);
        cmp("clrfs.pixel_on", 32'(pixel_on), 32'd0);

        // All-ones bytes saturate every field to its width, then reset mid-packet
        send_bytes(7, 8'hFF);
        cyc(0, 0, 8'h00, 1, 0, 1);
        check_model("ones");
        cmp("ones.v0_x", 32'(v0_x), 32'd127);
        cmp("ones.v1_y", 32'(v1_y), 32'd63);
        cmp("ones.colour", 32'(colour), 32'd63);
        send_bytes(3, 8'hFF);
        cyc(1, 1, 8'hFF, 1, 1, 1);
        check_model("rstmid");
        cmp("rstmid.v2_x", 32'(v2_x), 32'd0);
        cmp("rstmid.colour", 32'(colour), 32'd0);
        cmp("rstmid.in_ready", 32'(in_ready), 32'd1);
        cmp("rstmid.pending", 32'(pending), 32'd0);
        // after reset a whole new packet is needed before anything can swap
        send_bytes(6, 8'h0C);
        cyc(0, 0, 8'h00, 1, 0, 1);
        check_model("rstmid.partial_fs");
        cmp("rstmid.partial_fs_v0_x", 32'(v0_x), 32'd0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, 8'($urandom),
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4, 1'($urandom));
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
